// File: rtl/dmem_arb_pkg.sv
// Shared constants and helpers for the data-memory arbiters.
//   MEM_ADDR_W / MEM_DATA_W / MEM_BE_W : geometry of the 1024x32 byte-enabled memory
//   STAT_W                             : width of the optional per-requester grant counters
//   rr_next(ptr, n)                    : round-robin pointer advance with wrap at n-1 -> 0
package dmem_arb_pkg;

    localparam int unsigned MEM_ADDR_W = 10;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_BE_W   = 4;
    localparam int unsigned STAT_W     = 16;

    // Next round-robin start position after ptr was served.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 32'd0 : ptr + 1;
    endfunction

endpackage

// File: rtl/dmem_rr_arbiter_if.sv
// Bus bundle between NUM_REQ Avalon-MM data masters, the arbiter and the memory s1 port.
//   req_*  : per-requester slices (requester i occupies slice i), readdata is broadcast
//   mem_*  : single memory port (registered address, unregistered q)
//   modport slave  : arbiter view
//   modport master : view of the environment driving requests and modelling the memory
interface dmem_rr_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = MEM_ADDR_W,
    parameter int unsigned DATA_W  = MEM_DATA_W
) ();

    localparam int unsigned BE_W = DATA_W / 8;

    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ*BE_W-1:0]   req_byteenable;
    logic [NUM_REQ-1:0]        req_read;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*DATA_W-1:0] req_writedata;
    logic [NUM_REQ-1:0]        req_waitrequest;
    logic [DATA_W-1:0]         req_readdata;
    logic [NUM_REQ-1:0]        req_readdatavalid;

    logic [ADDR_W-1:0]         mem_address;
    logic [BE_W-1:0]           mem_byteenable;
    logic                      mem_chipselect;
    logic                      mem_write;
    logic [DATA_W-1:0]         mem_writedata;
    logic                      mem_clken;
    logic [DATA_W-1:0]         mem_readdata;

    modport slave (
        input  req_address, req_byteenable, req_read, req_write, req_writedata, mem_readdata,
        output req_waitrequest, req_readdata, req_readdatavalid,
               mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
    );

    modport master (
        output req_address, req_byteenable, req_read, req_write, req_writedata, mem_readdata,
        input  req_waitrequest, req_readdata, req_readdatavalid,
               mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin priority rotator.
//   i_active : request vector
//   i_ptr    : position that has highest priority this cycle
//   o_grant  : one-hot winner (all zero when nothing is active)
//   o_idx    : binary index of the winner
//   o_valid  : some requester won
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_active,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan i_ptr, i_ptr+1, ... modulo N and stop at the first active requester.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!o_valid && i_active[IDX_W'((32'(i_ptr) + k) % N)]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'((32'(i_ptr) + k) % N);
                o_grant[IDX_W'((32'(i_ptr) + k) % N)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port 1024x32 data memory between NUM_REQ masters.
//   clk, reset_n       : clock, asynchronous active-low reset
//   bus (slave)        : per-requester Avalon-MM slices and the memory s1 port
//   stat_clear         : (DMEM_ARB_STATS_EN only) pulse zeroing all grant counters
//   stat_grant_cnt     : (DMEM_ARB_STATS_EN only) NUM_REQ x 16-bit saturating grant counts
// Optional feature macro: DMEM_ARB_STATS_EN.
module dmem_rr_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = MEM_ADDR_W,
    parameter int unsigned DATA_W  = MEM_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    dmem_rr_arbiter_if.slave          bus
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic                      stat_clear,
    output logic [NUM_REQ*STAT_W-1:0] stat_grant_cnt
`endif
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] w_active;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [IDX_W-1:0]   w_win;
    logic               w_grant;
    logic [ADDR_W-1:0]  w_addr;
    logic [BE_W-1:0]    w_be;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_win_write;
    logic               w_win_read;
    logic [NUM_REQ-1:0] w_rdv;

    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_rd_id;
    logic               r_rd_pend;
    logic [ADDR_W-1:0]  r_last_addr;

    // Nobody is accepted while reset is held.
    assign w_active = reset_n ? (bus.req_read | bus.req_write) : '0;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_active (w_active),
        .i_ptr    (r_rr_ptr),
        .o_grant  (w_grant_oh),
        .o_idx    (w_win),
        .o_valid  (w_grant)
    );

    // Winner's payload mux; the address holds its last value when idle.
    always_comb begin
        w_addr      = r_last_addr;
        w_be        = '0;
        w_wdata     = '0;
        w_win_write = 1'b0;
        w_win_read  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_addr      = bus.req_address[i*ADDR_W +: ADDR_W];
                w_be        = bus.req_byteenable[i*BE_W +: BE_W];
                w_wdata     = bus.req_writedata[i*DATA_W +: DATA_W];
                w_win_write = bus.req_write[i];
                w_win_read  = bus.req_read[i] & ~bus.req_write[i];
            end
        end
    end

    // Read-return decode: one-hot pulse to the requester whose read was accepted last cycle.
    always_comb begin
        w_rdv = '0;
        if (r_rd_pend) begin
            w_rdv[r_rd_id] = 1'b1;
        end
    end

    assign bus.req_waitrequest   = ~w_grant_oh;
    assign bus.req_readdata      = bus.mem_readdata;
    assign bus.req_readdatavalid = w_rdv;
    assign bus.mem_address       = w_addr;
    assign bus.mem_byteenable    = w_be;
    assign bus.mem_writedata     = w_wdata;
    assign bus.mem_chipselect    = w_grant;
    assign bus.mem_clken         = w_grant;
    assign bus.mem_write         = w_grant & w_win_write;

    // Pointer, read-pending tracking and held address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr    <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_id     <= '0;
            r_last_addr <= '0;
        end else begin
            r_rd_pend <= w_grant & w_win_read;
            if (w_grant) begin
                r_rr_ptr    <= IDX_W'(rr_next(32'(w_win), NUM_REQ));
                r_last_addr <= w_addr;
            end
            if (w_grant && w_win_read) begin
                r_rd_id <= w_win;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_cnt [NUM_REQ];

    // Saturating grant counters; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_stat_cnt[i] <= '0;
            end
        end else if (stat_clear) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_stat_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (w_grant_oh[i] && (r_stat_cnt[i] != '1)) begin
                    r_stat_cnt[i] <= r_stat_cnt[i] + STAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        stat_grant_cnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            stat_grant_cnt[i*STAT_W +: STAT_W] = r_stat_cnt[i];
        end
    end
`endif

endmodule
